captura_botones: RTL and testbench
==================================

# captura_botones

Input front end for the snake controller: synchronises and debounces the five raw push-buttons, encodes each new press as a 3-bit button code, and delivers it to the move-memory stage as a one-cycle `LE` strobe with `boton_pres`. Simultaneous or back-to-back presses are queued in a pending mask and released one at a time. Every strobe is followed by at least one `LE`-low cycle, so the downstream stage always gets its fetch cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronised level must differ from the stable level before it is accepted (10 ms at 100 MHz).
- `REPEAT_CYCLES`, default 25_000_000: auto-repeat period. Used only with `AUTOREPEAT_EN`.
- `CNT_W`, default 25: counter width. Must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `btn_raw`  in  5  raw buttons, active-high. Bits: [0]=up, [1]=down, [2]=left, [3]=right, [4]=pause.
- `boton_pres`  out  3  button code: 1=up, 2=down, 3=left, 4=right, 5=pause. Valid only while `LE`=1; 0 otherwise.
- `LE`  out  1  load-enable strobe to the move-memory stage.
- `btn_estable`  out  5  debounced level of each button, for debug LEDs.

## Operation
- Per button: 2-flop synchroniser `s1`→`s2`, then the debouncer.
  - The counter increments while `s2` differs from `stable`. It clears to 0 on any cycle where they match.
  - At the edge where the counter equals DEBOUNCE_CYCLES-1 and `s2` still differs, `stable` takes the value of `s2` and the counter clears.
- A 0→1 transition of `stable[i]` sets `pend[i]` at the next edge. 1→0 transitions are ignored.
  - If `pend[i]` is already set, the new press coalesces and is not counted twice.
  - If a set and a clear of `pend[i]` occur in the same cycle, the set wins.
- Emitter FSM:
  - IDLE: if `pend`≠0, select the lowest set index k, go to EMIT, and clear `pend[k]`. Otherwise stay.
  - EMIT: drive `LE`=1 and `boton_pres`=k+1 for exactly one cycle, then go to GAP.
  - GAP: drive `LE`=0 and `boton_pres`=0 for one cycle, then go to IDLE.
  - Minimum strobe spacing is 3 cycles. Priority is up > down > left > right > pause.
- `LE` is registered (Moore output of EMIT). It never glitches and never has a 0 code while high.
- Reset values: `LE`=0, `boton_pres`=0, `btn_estable`=0, `pend`=0, all counters 0, FSM=IDLE, synchronisers 0.
- Reset mid-operation:
  - An in-flight strobe is dropped.
  - A button held through reset release is treated as a new press: it is re-emitted once after debounce.

## Timing
- Single-press latency: the raw level changes before edge E0 (first edge at which `s1` captures it). `stable` rises at E0+1+DEBOUNCE_CYCLES. `pend` sets at +1. FSM enters EMIT at +1. `LE` is high in the cycle after that edge.
  - Total: `LE` rises at edge E0+DEBOUNCE_CYCLES+3.
- Bounce: any sample where `s2` equals `stable` restarts the count. Glitches shorter than DEBOUNCE_CYCLES produce no strobe.
- N simultaneous presses produce N strobes spaced exactly 3 cycles apart, in priority order.

## Configuration
- `CAPTURA_AUTOREPEAT_EN` defined:
  - While `stable[i]`=1, a per-button repeat counter runs and re-sets `pend[i]` every REPEAT_CYCLES cycles.
  - The first repeat occurs REPEAT_CYCLES cycles after the press strobe's `pend` set.
  - The counter clears when `stable[i]` falls or on reset.
  - Pause (bit 4) never auto-repeats.
- Not defined: repeat counters are absent, and exactly one strobe is emitted per debounced press.

## Structure
- Shared package `snake_pkg`:
  - Button code constants: `BTN_NONE`=0, `BTN_UP`=1, `BTN_DOWN`=2, `BTN_LEFT`=3, `BTN_RIGHT`=4, `BTN_PAUSE`=5.
  - Button bit indices.
  - FSM state encoding IDLE/EMIT/GAP.
- Sub-module `antirrebote`: synchroniser plus debounce counter for one button, outputs `stable`. Instantiated 5 times.
- Pending mask, priority selection and FSM live in `captura_botones`.

## Test plan
- DEBOUNCE_CYCLES=4. Hold `btn_raw`=5'b00001 → `LE`=1 with `boton_pres`=1 for one cycle at E0+7; `btn_estable`=00001. No further strobe while held.
- Raw up-bit toggles every 2 cycles for 40 cycles, then settles low → no `LE` pulse; `btn_estable` stays 0.
- `btn_raw`=5'b10110 applied in one cycle → strobes with codes 2, 3, 5, each `LE` high one cycle, rising edges 3 cycles apart.
- Press right. Assert `rst`=0 for 2 cycles during its EMIT cycle while still holding, then release reset → `LE`=0 immediately. After reset release, `boton_pres`=4 is emitted once more after debounce.
- Pause pending while up is pressed → up (code 1) is emitted first, then pause (code 5); the intervening cycle has `LE`=0 and `boton_pres`=0.
- With `CAPTURA_AUTOREPEAT_EN`, REPEAT_CYCLES=10, hold left for 35 cycles after debounce → four strobes with code 3: the press plus 3 repeats. Holding pause → one strobe only.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake controller: button codes, button bit
// positions and the emitter state encoding.
package snake_pkg;

    localparam int NUM_BTN = 5;

    localparam logic [2:0] BTN_NONE  = 3'd0;
    localparam logic [2:0] BTN_UP    = 3'd1;
    localparam logic [2:0] BTN_DOWN  = 3'd2;
    localparam logic [2:0] BTN_LEFT  = 3'd3;
    localparam logic [2:0] BTN_RIGHT = 3'd4;
    localparam logic [2:0] BTN_PAUSE = 3'd5;

    localparam int BIT_UP    = 0;
    localparam int BIT_DOWN  = 1;
    localparam int BIT_LEFT  = 2;
    localparam int BIT_RIGHT = 3;
    localparam int BIT_PAUSE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } estado_t;

    // Lowest set bit wins, giving up > down > left > right > pause.
    function automatic logic [2:0] idx_prioridad(input logic [NUM_BTN-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/captura_botones_antirrebote.sv
// One-button front end: two-flop synchroniser followed by a debounce
// counter that accepts a new level after DEBOUNCE_CYCLES consecutive samples.
module antirrebote #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            // Any sample agreeing with the accepted level restarts the count.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_TC) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/captura_botones.sv
// Button capture front end: debounce, pending-press queue and one-cycle LE
// strobe emitter. Define CAPTURA_AUTOREPEAT_EN to enable held-button repeat.
module captura_botones
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [2:0]         boton_pres,
    output logic               LE,
    output logic [NUM_BTN-1:0] btn_estable
);

    logic [NUM_BTN-1:0] w_stable;
    logic [NUM_BTN-1:0] r_stable_d;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_rpt_set;
    logic [NUM_BTN-1:0] r_pend;
    logic [NUM_BTN-1:0] w_clr;
    logic [2:0]         w_sel_idx;
    estado_t            r_state;
    estado_t            w_state_nx;
    logic               r_le;
    logic               w_le_nx;
    logic [2:0]         r_code;
    logic [2:0]         w_code_nx;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        antirrebote #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_antirrebote (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (btn_raw[g]),
            .o_stable (w_stable[g])
        );
    end

    assign w_rise = w_stable & ~r_stable_d;

`ifdef CAPTURA_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_TC = CNT_W'(REPEAT_CYCLES - 1);

    // Pause is deliberately left out: only the four direction buttons repeat.
    logic [CNT_W-1:0] r_rpt_cnt [BIT_PAUSE];

    always_comb begin
        w_rpt_set = '0;
        for (int i = 0; i < BIT_PAUSE; i++) begin
            w_rpt_set[i] = w_stable[i] && !w_rise[i] && (r_rpt_cnt[i] == RPT_TC);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BIT_PAUSE; i++) r_rpt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < BIT_PAUSE; i++) begin
                if (!w_stable[i] || w_rise[i] || w_rpt_set[i]) begin
                    r_rpt_cnt[i] <= '0;
                end else begin
                    r_rpt_cnt[i] <= r_rpt_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign w_rpt_set = '0;
`endif

    assign w_sel_idx = idx_prioridad(r_pend);

    always_comb begin
        w_state_nx = r_state;
        w_clr      = '0;
        w_le_nx    = 1'b0;
        w_code_nx  = BTN_NONE;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    w_state_nx = ST_EMIT;
                    w_clr      = NUM_BTN'(1) << w_sel_idx;
                    w_le_nx    = 1'b1;
                    w_code_nx  = w_sel_idx + 3'd1;
                end
            end
            ST_EMIT: w_state_nx = ST_GAP;
            ST_GAP:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // LE and the code are registered alongside the state so they track EMIT exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_d <= '0;
            r_pend     <= '0;
            r_state    <= ST_IDLE;
            r_le       <= 1'b0;
            r_code     <= BTN_NONE;
        end else begin
            r_stable_d <= w_stable;
            r_pend     <= (r_pend & ~w_clr) | w_rise | w_rpt_set;
            r_state    <= w_state_nx;
            r_le       <= w_le_nx;
            r_code     <= w_code_nx;
        end
    end

    assign LE          = r_le;
    assign boton_pres  = r_code;
    assign btn_estable = w_stable;

endmodule

// File: tb/tb_captura_botones.sv
// Directed bench for captura_botones; expected strobes are queued with their
// code and arrival cycle and checked by a negedge monitor.
module tb_captura_botones;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [2:0] boton_pres;
    logic       LE;
    logic [4:0] btn_estable;

    int   cyc;
    int   n_checks;
    int   n_fail;
    logic prev_le;
    exp_t sb_q[$];

    captura_botones #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (10),
        .CNT_W           (25)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .boton_pres  (boton_pres),
        .LE          (LE),
        .btn_estable (btn_estable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every LE-high sample must match the head of the queue.
    initial prev_le = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (LE === 1'b1) begin
            n_checks++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_strobe observed code=%0d at cyc=%0d expected no strobe", boton_pres, cyc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_checks++;
                assert (boton_pres === e.code) else begin
                    n_fail++;
                    $error("FAIL strobe_code observed=%0d expected=%0d", boton_pres, e.code);
                end
                n_checks++;
                assert (cyc === e.cyc) else begin
                    n_fail++;
                    $error("FAIL strobe_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
            n_checks++;
            assert (prev_le === 1'b0) else begin
                n_fail++;
                $error("FAIL le_width observed=2+ cycles high expected=1");
            end
        end else begin
            n_checks++;
            assert (boton_pres === 3'd0) else begin
                n_fail++;
                $error("FAIL code_idle observed=%0d expected=0 with LE=%b", boton_pres, LE);
            end
        end
        prev_le = LE;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [2:0] code, input int at_cyc);
        exp_t e;
        e.code = code;
        e.cyc  = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic check_stable(input logic [4:0] exp_v, input string tag);
        n_checks++;
        assert (btn_estable === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed btn_estable=%b expected=%b", tag, btn_estable, exp_v);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) wait_cycles(1);
        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL %s observed %0d strobes outstanding expected=0", tag, sb_q.size());
        end
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        btn_raw  = 5'b00000;

        wait_cycles(3);
        n_checks++;
        assert (LE === 1'b0 && boton_pres === 3'd0 && btn_estable === 5'b00000) else begin
            n_fail++;
            $error("FAIL reset_values observed LE=%b code=%0d stable=%b expected 0/0/00000", LE, boton_pres, btn_estable);
        end
        rst = 1'b1;
        wait_cycles(3);

`ifndef CAPTURA_AUTOREPEAT_EN
        // Single press held long: one strobe only.
        k = cyc;
        btn_raw = 5'b00001;
        push_exp(3'd1, k + 8);
        wait_cycles(6);
        check_stable(5'b00001, "press_stable");
        wait_cycles(24);
        btn_raw = 5'b00000;
        wait_cycles(15);
        check_stable(5'b00000, "release_stable");
        drain("single_press");

        // Bouncing input shorter than the debounce window.
        for (int i = 0; i < 20; i++) begin
            btn_raw[0] = ~btn_raw[0];
            wait_cycles(2);
            check_stable(5'b00000, "bounce_stable");
        end
        btn_raw = 5'b00000;
        wait_cycles(12);
        check_stable(5'b00000, "bounce_settled");

        // Simultaneous down/left/pause.
        k = cyc;
        btn_raw = 5'b10110;
        push_exp(3'd2, k + 8);
        push_exp(3'd3, k + 11);
        push_exp(3'd5, k + 14);
        wait_cycles(16);
        check_stable(5'b10110, "multi_stable");
        btn_raw = 5'b00000;
        wait_cycles(15);
        drain("multi_press");

        // Reset during the EMIT cycle while holding right.
        k = cyc;
        btn_raw = 5'b01000;
        wait_cycles(8);
        n_checks++;
        assert (LE === 1'b1 && boton_pres === 3'd4) else begin
            n_fail++;
            $error("FAIL reset_pre_emit observed LE=%b code=%0d expected 1/4", LE, boton_pres);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        assert (LE === 1'b0 && boton_pres === 3'd0) else begin
            n_fail++;
            $error("FAIL reset_drop observed LE=%b code=%0d expected 0/0", LE, boton_pres);
        end
        wait_cycles(2);
        rst = 1'b1;
        k = cyc;
        push_exp(3'd4, k + 8);
        wait_cycles(12);
        btn_raw = 5'b00000;
        wait_cycles(15);
        drain("reset_reemit");

        // Up and pause together: up first, gap cycle, then pause.
        k = cyc;
        btn_raw = 5'b10001;
        push_exp(3'd1, k + 8);
        push_exp(3'd5, k + 11);
        wait_cycles(14);
        btn_raw = 5'b00000;
        wait_cycles(15);
        drain("priority");
`else
        // Held left repeats every REPEAT_CYCLES after the press.
        k = cyc;
        btn_raw = 5'b00100;
        push_exp(3'd3, k + 8);
        push_exp(3'd3, k + 18);
        push_exp(3'd3, k + 28);
        push_exp(3'd3, k + 38);
        wait_cycles(6);
        check_stable(5'b00100, "rpt_stable");
        wait_cycles(30);
        btn_raw = 5'b00000;
        wait_cycles(20);
        drain("autorepeat_left");

        // Held pause never repeats.
        k = cyc;
        btn_raw = 5'b10000;
        push_exp(3'd5, k + 8);
        wait_cycles(40);
        btn_raw = 5'b00000;
        wait_cycles(15);
        drain("autorepeat_pause");
`endif

        wait_cycles(5);
        check_stable(5'b00000, "final_stable");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
